// File: rtl/max16_pkg.sv
// Shared definitions for the max16 lane-select datapath: widths, FSM states
// and the wrapping index increment.
package max16_pkg;

    localparam int IDX_W = 5;
    localparam int OUT_W = 1 << IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/decoder5x32.sv
// Purely combinational 5-to-32 one-hot decoder; exact inverse of encoder32x5.
module decoder5x32
    import max16_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [OUT_W-1:0] o_onehot
);

    assign o_onehot = OUT_W'(1) << i_idx;

endmodule

// File: rtl/onehot_sweep_decoder.sv
// Streaming index/range to one-hot decoder: accepts single or sweep requests
// and emits one registered one-hot select word per handshake beat.
module onehot_sweep_decoder
    import max16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [IDX_W-1:0] in_last_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    state_t           r_state;
    logic [IDX_W-1:0] r_cur;
    logic [IDX_W-1:0] r_end;
    logic [IDX_W-1:0] r_out_idx;
    logic [OUT_W-1:0] r_out_onehot;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_accept;
    logic             w_handshake;
    logic             w_advance;
    logic             w_load;
    logic [IDX_W-1:0] w_cur_nxt;
    logic [IDX_W-1:0] w_end_nxt;
    logic [OUT_W-1:0] w_onehot_nxt;

    // Ready during the final beat lets a new request follow with no bubble.
    assign in_ready    = (r_state == IDLE) | (out_ready & r_out_last);
    assign w_accept    = in_valid & in_ready;
    assign w_handshake = r_out_valid & out_ready;
    assign w_advance   = w_handshake & ~r_out_last;
    assign w_load      = w_accept | w_advance;

    always_comb begin
        w_cur_nxt = next_idx(r_cur);
        w_end_nxt = r_end;
        if (w_accept) begin
            w_cur_nxt = in_idx;
            w_end_nxt = in_mode ? in_last_idx : in_idx;
        end
    end

    decoder5x32 u_dec (
        .i_idx    (w_cur_nxt),
        .o_onehot (w_onehot_nxt)
    );

    // Outputs are loaded from the next index so the beat appears right after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_end        <= '0;
            r_out_valid  <= 1'b0;
            r_out_onehot <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
        end else if (w_load) begin
            r_state      <= EMIT;
            r_cur        <= w_cur_nxt;
            r_end        <= w_end_nxt;
            r_out_valid  <= 1'b1;
            r_out_onehot <= w_onehot_nxt;
            r_out_idx    <= w_cur_nxt;
            r_out_last   <= (w_cur_nxt == w_end_nxt);
        end else if (w_handshake) begin
            r_state      <= IDLE;
            r_out_valid  <= 1'b0;
            r_out_onehot <= '0;
            r_out_last   <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_onehot = r_out_onehot;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_onehot_sweep_decoder.sv
// Self-checking bench for onehot_sweep_decoder: directed scenarios plus a
// randomized run against a queue-based beat model.
module tb_onehot_sweep_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode;
    logic [4:0]  in_idx, in_last_idx;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_onehot;
    logic [4:0]  out_idx;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    onehot_sweep_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_idx      (in_idx),
        .in_last_idx (in_last_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_onehot  (out_onehot),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic m, input logic [4:0] i,
                         input logic [4:0] l, input logic r);
        in_valid    = v;
        in_mode     = m;
        in_idx      = i;
        in_last_idx = l;
        out_ready   = r;
        #1;
    endtask

    // Advance one clock and update the reference: a request expands into its list of beats.
    task automatic step();
        logic acc, hs;
        int   len, i, l;
        acc = in_valid & in_ready;
        hs  = out_valid & out_ready;
        i   = int'(in_idx);
        l   = in_mode ? int'(in_last_idx) : int'(in_idx);
        @(posedge clk);
        if (hs && exp_q.size() > 0) exp_q.delete(0);
        if (acc) begin
            len = ((l - i + 32) % 32) + 1;
            for (int k = 0; k < len; k++) exp_q.push_back('{(i + k) % 32, k == len - 1});
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_onehot !== 32'h0) begin n_bad++; $display("FAIL reset_onehot: got %h want 0", out_onehot); end
        n_cmp++; if (out_idx !== 5'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        drive(1, 0, 5, 17, 1);
        step();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_onehot !== 32'h00000020) begin n_bad++; $display("FAIL single_onehot: got %h want 00000020", out_onehot); end
        n_cmp++; if (out_idx !== 5'd5) begin n_bad++; $display("FAIL single_idx: got %0d want 5", out_idx); end
        n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b want 1", out_last); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_wrap_sweep();
        logic [31:0] exp_oh [4] = '{32'h40000000, 32'h80000000, 32'h00000001, 32'h00000002};
        logic [4:0]  exp_ix [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        drive(1, 1, 30, 1, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++; if (out_idx !== exp_ix[k] || out_onehot !== exp_oh[k] || out_valid !== 1'b1)
                begin n_bad++; $display("FAIL wrap_beat%0d: got idx=%0d oh=%h want idx=%0d oh=%h", k, out_idx, out_onehot, exp_ix[k], exp_oh[k]); end
            n_cmp++; if (out_last !== (k == 3))
                begin n_bad++; $display("FAIL wrap_last%0d: got %b want %b", k, out_last, (k == 3)); end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_done: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic ordy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int   seen[$];
        drive(1, 1, 0, 3, 1);
        step();
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 0, ordy[c]);
            if (c == 1 || c == 2) begin
                n_cmp++; if (out_onehot !== 32'h2 || out_idx !== 5'd1 || out_last !== 1'b0 || out_valid !== 1'b1)
                    begin n_bad++; $display("FAIL stall_hold%0d: got oh=%h idx=%0d last=%b want oh=00000002 idx=1 last=0", c, out_onehot, out_idx, out_last); end
            end
            if (out_valid && out_ready) seen.push_back(int'(out_idx));
            step();
        end
        n_cmp++; if (seen.size() != 4) begin n_bad++; $display("FAIL stall_count: got %0d beats want 4", seen.size()); end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            n_cmp++; if (seen[k] != k) begin n_bad++; $display("FAIL stall_order%0d: got %0d want %0d", k, seen[k], k); end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_done: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 31, 0, 1);
        step();
        drive(1, 0, 0, 0, 1);
        n_cmp++; if (out_onehot !== 32'h80000000 || out_last !== 1'b1)
            begin n_bad++; $display("FAIL b2b_first: got oh=%h last=%b want 80000000 1", out_onehot, out_last); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        step();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b1 || out_onehot !== 32'h00000001 || out_last !== 1'b1)
            begin n_bad++; $display("FAIL b2b_second: got valid=%b oh=%h last=%b want 1 00000001 1", out_valid, out_onehot, out_last); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_full_sweep();
        logic [31:0] seen = '0;
        logic [31:0] final_oh = '0;
        logic        final_last = 1'b0;
        int          beats = 0, dup = 0, nlast = 0;
        drive(1, 1, 7, 6, 1);
        step();
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, 0, 1);
            if (!out_valid) break;
            if ((seen & out_onehot) != 0) dup++;
            seen |= out_onehot;
            beats++;
            if (out_last) nlast++;
            final_oh   = out_onehot;
            final_last = out_last;
            step();
        end
        n_cmp++; if (beats != 32) begin n_bad++; $display("FAIL full_beats: got %0d want 32", beats); end
        n_cmp++; if (seen !== 32'hFFFFFFFF || dup != 0) begin n_bad++; $display("FAIL full_cover: got seen=%h dup=%0d want FFFFFFFF 0", seen, dup); end
        n_cmp++; if (nlast != 1) begin n_bad++; $display("FAIL full_nlast: got %0d want 1", nlast); end
        n_cmp++; if (final_oh !== 32'h00000040 || final_last !== 1'b1)
            begin n_bad++; $display("FAIL full_final: got oh=%h last=%b want 00000040 1", final_oh, final_last); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 9, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        step();
        n_cmp++; if (out_idx !== 5'd2 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_beat3: got idx=%0d valid=%b want 2 1", out_idx, out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_onehot !== 32'h0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_clear: got valid=%b oh=%h busy=%b want 0 0 0", out_valid, out_onehot, busy); end
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_release: got ready=%b busy=%b valid=%b want 1 0 0", in_ready, busy, out_valid); end
        drive(1, 0, 2, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b1 || out_onehot !== 32'h00000004)
            begin n_bad++; $display("FAIL rstmid_new: got valid=%b oh=%h want 1 00000004", out_valid, out_onehot); end
        step();
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 3) != 0));
            exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
            n_cmp++; if (out_valid !== (exp_q.size() != 0) || busy !== (exp_q.size() != 0))
                begin n_bad++; $display("FAIL rand_valid@%0d: got valid=%b busy=%b want %b", c, out_valid, busy, exp_q.size() != 0); end
            n_cmp++; if (in_ready !== exp_rdy)
                begin n_bad++; $display("FAIL rand_ready@%0d: got %b want %b", c, in_ready, exp_rdy); end
            if (exp_q.size() != 0) begin
                n_cmp++; if (int'(out_idx) != exp_q[0].idx || out_onehot !== (32'h1 << exp_q[0].idx) || out_last !== exp_q[0].last)
                    begin n_bad++; $display("FAIL rand_beat@%0d: got idx=%0d oh=%h last=%b want idx=%0d last=%b", c, out_idx, out_onehot, out_last, exp_q[0].idx, exp_q[0].last); end
            end else begin
                n_cmp++; if (out_onehot !== 32'h0) begin n_bad++; $display("FAIL rand_zero@%0d: got oh=%h want 0", c, out_onehot); end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_sweep();
        test_stall();
        test_back_to_back();
        test_full_sweep();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
